// File: rtl/flow_init_sequencer_pkg.sv
// Shared definitions for the flow-context init sequencer: FSM states and
// the per-channel init-word layout inside the packed init_data/wr_data buses.
package flow_init_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SWEEP,
    FREE,
    RUNNING,
    RE_WR,
    RE_PUSH
  } fis_state_t;

  // LSB of channel chan's word within a NUM_CHAN*data_w packed bus.
  function automatic int chan_lsb(input int chan, input int data_w);
    return chan * data_w;
  endfunction

endpackage

// File: rtl/flow_init_req_fifo.sv
// Re-init request queue: DEPTH x WIDTH, count-based full/empty, flush drops
// all entries. Head is visible on pop_data whenever empty is low.
module flow_init_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset_finished,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  input  logic             flush,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == DEPTH_CNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or posedge reset_finished) begin
    if (reset_finished) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + (PTR_W + 1)'(1);
      else if (do_pop && !do_push) count <= count - (PTR_W + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/flow_init_sequencer.sv
// Sweeps every flow context across NUM_CHAN write channels, seeds the free-flow
// FIFO with all ids, then services single-flow re-init requests from a queue.
module flow_init_sequencer
  import flow_init_sequencer_pkg::*;
#(
  parameter int NUM_FLOWS  = 1024,
  parameter int FLOW_ID_W  = 10,
  parameter int NUM_CHAN   = 4,
  parameter int DATA_W     = 64,
  parameter int REQ_DEPTH  = 4,
  parameter int AUTO_START = 1
) (
  input  logic                         clk,
  input  logic                         reset_finished,
  input  logic                         init_start,
  input  logic [NUM_CHAN*DATA_W-1:0]   init_data,
  output logic [NUM_CHAN-1:0]          wr_val,
  input  logic [NUM_CHAN-1:0]          wr_rdy,
  output logic [FLOW_ID_W-1:0]         wr_addr,
  output logic [NUM_CHAN*DATA_W-1:0]   wr_data,
  output logic                         fl_push_val,
  input  logic                         fl_push_rdy,
  output logic [FLOW_ID_W-1:0]         fl_push_id,
  input  logic                         reinit_val,
  output logic                         reinit_rdy,
  input  logic [FLOW_ID_W-1:0]         reinit_id,
  output logic                         init_done,
  output logic                         busy,
  output logic                         err_bad_id
);

  localparam logic [FLOW_ID_W-1:0] LAST_ID    = FLOW_ID_W'(NUM_FLOWS - 1);
  localparam logic [FLOW_ID_W:0]   FLOW_LIMIT = (FLOW_ID_W + 1)'(NUM_FLOWS);

  fis_state_t           state_q, state_d;
  logic [FLOW_ID_W-1:0] cnt_q, cnt_d;
  logic [FLOW_ID_W-1:0] cur_id_q, cur_id_d;
  logic [NUM_CHAN-1:0]  done_q, done_d;
  logic                 init_done_q, init_done_d;
  logic                 err_q;

  logic [NUM_CHAN-1:0]  wr_accept;
  logic                 all_acc;
  logic                 reinit_hs;
  logic                 id_ok;
  logic                 q_push, q_pop, q_flush, q_full, q_empty;
  logic [FLOW_ID_W-1:0] q_head;
  logic                 single_flow;

  flow_init_req_fifo #(
    .DEPTH (REQ_DEPTH),
    .WIDTH (FLOW_ID_W)
  ) u_req_fifo (
    .clk            (clk),
    .reset_finished (reset_finished),
    .push           (q_push),
    .push_data      (reinit_id),
    .pop            (q_pop),
    .pop_data       (q_head),
    .flush          (q_flush),
    .full           (q_full),
    .empty          (q_empty)
  );

  // All valids come from registered state only; no rdy-to-val path.
  assign single_flow = (state_q == RE_WR) || (state_q == RE_PUSH);
  assign wr_val      = ((state_q == SWEEP) || (state_q == RE_WR)) ? ~done_q : '0;
  assign wr_addr     = single_flow ? cur_id_q : cnt_q;
  assign fl_push_val = (state_q == FREE) || (state_q == RE_PUSH);
  assign fl_push_id  = single_flow ? cur_id_q : cnt_q;
  assign busy        = (state_q == SWEEP) || (state_q == FREE) ||
                       (state_q == RE_WR) || (state_q == RE_PUSH);
  assign init_done   = init_done_q;
  assign err_bad_id  = err_q;
  assign reinit_rdy  = init_done_q && !q_full;

  for (genvar c = 0; c < NUM_CHAN; c++) begin : g_wr_data
    assign wr_data[chan_lsb(c, DATA_W) +: DATA_W] = init_data[chan_lsb(c, DATA_W) +: DATA_W];
  end

  // A channel that already took this address stays masked until all have.
  assign wr_accept = done_q | (wr_val & wr_rdy);
  assign all_acc   = &wr_accept;

  assign reinit_hs = reinit_val && reinit_rdy;
  assign id_ok     = ({1'b0, reinit_id} < FLOW_LIMIT);
  assign q_push    = reinit_hs && id_ok && !((state_q == RUNNING) && init_start);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cur_id_d    = cur_id_q;
    done_d      = done_q;
    init_done_d = init_done_q;
    q_pop       = 1'b0;
    q_flush     = 1'b0;
    case (state_q)
      IDLE: begin
        if ((AUTO_START != 0) || init_start) begin
          state_d = SWEEP;
          cnt_d   = '0;
          done_d  = '0;
        end
      end
      SWEEP: begin
        if (all_acc) begin
          done_d = '0;
          if (cnt_q == LAST_ID) begin
            cnt_d   = '0;
            state_d = FREE;
          end else begin
            cnt_d = cnt_q + FLOW_ID_W'(1);
          end
        end else begin
          done_d = wr_accept;
        end
      end
      FREE: begin
        if (fl_push_rdy) begin
          if (cnt_q == LAST_ID) begin
            cnt_d       = '0;
            state_d     = RUNNING;
            init_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + FLOW_ID_W'(1);
          end
        end
      end
      RUNNING: begin
        // A full re-sweep supersedes any queued single-flow work.
        if (init_start) begin
          q_flush = 1'b1;
          state_d = SWEEP;
          cnt_d   = '0;
          done_d  = '0;
        end else if (!q_empty) begin
          q_pop    = 1'b1;
          cur_id_d = q_head;
          done_d   = '0;
          state_d  = RE_WR;
        end
      end
      RE_WR: begin
        if (all_acc) begin
          done_d  = '0;
          state_d = RE_PUSH;
        end else begin
          done_d = wr_accept;
        end
      end
      RE_PUSH: begin
        if (fl_push_rdy) state_d = RUNNING;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_finished) begin
    if (reset_finished) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cur_id_q    <= '0;
      done_q      <= '0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_id_q    <= cur_id_d;
      done_q      <= done_d;
      init_done_q <= init_done_d;
      err_q       <= reinit_hs && !id_ok;
    end
  end

endmodule

// File: tb/tb_flow_init_sequencer.sv
// Directed bench for flow_init_sequencer with an expected-transfer scoreboard.
module tb_flow_init_sequencer;

  localparam int NF  = 4;
  localparam int IDW = 3;
  localparam int NC  = 2;
  localparam int DW  = 16;

  logic            clk = 1'b0;
  logic            reset_finished = 1'b1;
  logic            init_start = 1'b0;
  logic [NC*DW-1:0] init_data = '0;
  logic [NC-1:0]   wr_val;
  logic [NC-1:0]   wr_rdy = 2'b11;
  logic [IDW-1:0]  wr_addr;
  logic [NC*DW-1:0] wr_data;
  logic            fl_push_val;
  logic            fl_push_rdy = 1'b1;
  logic [IDW-1:0]  fl_push_id;
  logic            reinit_val = 1'b0;
  logic            reinit_rdy;
  logic [IDW-1:0]  reinit_id = '0;
  logic            init_done;
  logic            busy;
  logic            err_bad_id;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_wr0[$];
  int exp_wr1[$];
  int exp_push[$];

  always #5 clk = ~clk;

  flow_init_sequencer #(
    .NUM_FLOWS (NF), .FLOW_ID_W (IDW), .NUM_CHAN (NC),
    .DATA_W (DW), .REQ_DEPTH (2), .AUTO_START (1)
  ) dut (
    .clk (clk), .reset_finished (reset_finished), .init_start (init_start),
    .init_data (init_data), .wr_val (wr_val), .wr_rdy (wr_rdy),
    .wr_addr (wr_addr), .wr_data (wr_data), .fl_push_val (fl_push_val),
    .fl_push_rdy (fl_push_rdy), .fl_push_id (fl_push_id),
    .reinit_val (reinit_val), .reinit_rdy (reinit_rdy), .reinit_id (reinit_id),
    .init_done (init_done), .busy (busy), .err_bad_id (err_bad_id)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // A full sweep: every address on every channel ascending, then every id pushed ascending.
  task automatic expect_sweep();
    for (int a = 0; a < NF; a++) begin
      exp_wr0.push_back(a);
      exp_wr1.push_back(a);
    end
    for (int a = 0; a < NF; a++) exp_push.push_back(a);
  endtask

  task automatic expect_reinit(input int id);
    exp_wr0.push_back(id);
    exp_wr1.push_back(id);
    exp_push.push_back(id);
  endtask

  task automatic clear_expect();
    exp_wr0.delete();
    exp_wr1.delete();
    exp_push.delete();
  endtask

  function automatic int pending();
    return exp_wr0.size() + exp_wr1.size() + exp_push.size();
  endfunction

  task automatic wait_quiet(input int max, input string name);
    for (int i = 0; i < max; i++) begin
      if (!busy && pending() == 0) break;
      step(1);
    end
    check({name, " busy"}, busy, 0);
    check({name, " pending"}, pending(), 0);
  endtask

  task automatic wait_addr(input int a, input int max);
    for (int i = 0; i < max; i++) begin
      if ((|wr_val) && wr_addr == a) break;
      step(1);
    end
    check("reach sweep addr", {|wr_val, wr_addr}, {1'b1, 3'(a)});
  endtask

  // Compare process: every transfer that will happen on the next edge is checked here.
  always @(negedge clk) begin
    if (!reset_finished) begin
      if (wr_val[0] && wr_rdy[0]) begin
        if (exp_wr0.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected write ch0: addr %0d, none expected", wr_addr);
        end else begin
          check("write addr ch0", wr_addr, exp_wr0.pop_front());
          check("write data ch0", wr_data[DW-1:0], init_data[DW-1:0]);
        end
      end
      if (wr_val[1] && wr_rdy[1]) begin
        if (exp_wr1.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected write ch1: addr %0d, none expected", wr_addr);
        end else begin
          check("write addr ch1", wr_addr, exp_wr1.pop_front());
          check("write data ch1", wr_data[2*DW-1:DW], init_data[2*DW-1:DW]);
        end
      end
      if (fl_push_val && fl_push_rdy) begin
        if (exp_push.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected push: id %0d, none expected", fl_push_id);
        end else begin
          check("push id", fl_push_id, exp_push.pop_front());
        end
      end
      check("write/push exclusive", (|wr_val) && fl_push_val, 0);
      check("busy covers valids", ((|wr_val) || fl_push_val) && !busy, 0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    init_data = {16'hBEEF, 16'h1234};
    step(2);
    check("reset wr_val", wr_val, 0);
    check("reset fl_push_val", fl_push_val, 0);
    check("reset reinit_rdy", reinit_rdy, 0);
    check("reset init_done", init_done, 0);
    check("reset busy", busy, 0);
    check("reset err_bad_id", err_bad_id, 0);
    check("reset wr_addr", wr_addr, 0);
    check("reset fl_push_id", fl_push_id, 0);

    // Auto-start sweep with everything ready: 1 start + 4 writes + 4 pushes.
    expect_sweep();
    reset_finished = 1'b0;
    cyc = 0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      cyc++;
      if (cyc == 1) begin
        check("first write valid", wr_val, 2'b11);
        check("first write addr", wr_addr, 0);
      end
      if (cyc == 3) check("reinit_rdy before done", reinit_rdy, 0);
      if (init_done) break;
    end
    check("cycles to init_done", cyc, 9);
    check("init_done set", init_done, 1);
    check("busy after init", busy, 0);
    check("reinit_rdy after init", reinit_rdy, 1);
    check("sweep A pending", pending(), 0);

    // Re-sweep with channel 1 stalled for 3 cycles at address 2; init_start in FREE ignored.
    init_data = {16'hA5A5, 16'h0F0F};
    expect_sweep();
    init_start = 1'b1;
    step(1);
    init_start = 1'b0;
    check("busy in sweep", busy, 1);
    check("init_done sticky", init_done, 1);
    wait_addr(2, 20);
    wr_rdy = 2'b01;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("stall addr", wr_addr, 2);
      check("stall val", wr_val, 2'b10);
    end
    wr_rdy = 2'b11;
    step(1);
    check("advance addr", wr_addr, 3);
    check("advance val", wr_val, 2'b11);
    for (int i = 0; i < 20; i++) begin
      if (fl_push_val) break;
      step(1);
    end
    check("reached FREE", fl_push_val, 1);
    init_start = 1'b1;
    step(1);
    init_start = 1'b0;
    wait_quiet(40, "sweep B");
    check("init_done after B", init_done, 1);

    // Queue ids 3 and 1 during a sweep; a third request sees a full queue.
    expect_sweep();
    expect_reinit(3);
    expect_reinit(1);
    init_start = 1'b1;
    step(1);
    init_start = 1'b0;
    reinit_val = 1'b1;
    reinit_id  = 3'd3;
    check("reinit_rdy q empty", reinit_rdy, 1);
    step(1);
    reinit_id = 3'd1;
    check("reinit_rdy q one", reinit_rdy, 1);
    step(1);
    reinit_id = 3'd0;
    check("reinit_rdy q full", reinit_rdy, 0);
    step(1);
    check("reinit_rdy still full", reinit_rdy, 0);
    reinit_val = 1'b0;
    wait_quiet(60, "reinit C");

    // Queued id 2 flushed by init_start; a simultaneous request is discarded.
    expect_sweep();
    reinit_val = 1'b1;
    reinit_id  = 3'd2;
    step(1);
    reinit_id  = 3'd1;
    init_start = 1'b1;
    step(1);
    reinit_val = 1'b0;
    init_start = 1'b0;
    wait_quiet(40, "flush D");
    step(4);
    check("idle after flush", busy, 0);

    // Out-of-range id is dropped with a one-cycle error pulse.
    check("err idle", err_bad_id, 0);
    check("reinit_rdy before bad id", reinit_rdy, 1);
    reinit_val = 1'b1;
    reinit_id  = 3'd7;
    step(1);
    reinit_val = 1'b0;
    check("err pulse", err_bad_id, 1);
    step(1);
    check("err pulse end", err_bad_id, 0);
    step(4);
    check("no work after bad id", busy, 0);

    // Reset in the middle of a sweep aborts; the auto-start sweep restarts at 0.
    expect_sweep();
    init_start = 1'b1;
    step(1);
    init_start = 1'b0;
    wait_addr(2, 20);
    reset_finished = 1'b1;
    #1;
    check("abort wr_val", wr_val, 0);
    check("abort fl_push_val", fl_push_val, 0);
    check("abort reinit_rdy", reinit_rdy, 0);
    check("abort init_done", init_done, 0);
    check("abort busy", busy, 0);
    check("abort err_bad_id", err_bad_id, 0);
    check("abort wr_addr", wr_addr, 0);
    check("abort fl_push_id", fl_push_id, 0);
    clear_expect();
    step(2);
    expect_sweep();
    reset_finished = 1'b0;
    step(1);
    check("restart addr", wr_addr, 0);
    check("restart val", wr_val, 2'b11);
    check("restart init_done", init_done, 0);
    wait_quiet(40, "restart F");
    check("init_done after restart", init_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
